sprite_rom_arbiter: RTL and testbench

SPRITE_ROM_ARBITER -- requirements
Module: sprite_rom_arbiter

---
 rtl/sprite_rom_arbiter_pkg.sv | 20 ++
 rtl/sprite_rom_arbiter_rr_pick.sv | 32 +++
 rtl/sprite_rom_arbiter.sv | 108 ++++++++++
 tb/tb_sprite_rom_arbiter.sv | 425 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sprite_rom_arbiter_pkg.sv
// Shared constants and types for the sprite ROM arbiter: parameter defaults,
// status counter width, RGB444 pixel type and the transparent colour.
package sprite_rom_arbiter_pkg;

    localparam int SRA_NUM_REQ     = 4;
    localparam int SRA_ADDR_W      = 19;
    localparam int SRA_DATA_W      = 12;
    localparam int SRA_ROM_LATENCY = 2;
    localparam int SRA_CNT_W       = 16;

    typedef logic [11:0] rgb444_t;

    localparam rgb444_t TRANSPARENT = 12'h000;

    // Pointer width stays at least one bit so a single-requester build still elaborates.
    function automatic int sra_ptr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sprite_rom_arbiter_rr_pick.sv
// rr_pick: combinational circular priority pick starting at i_ptr.
// Only defined when SPRITE_ARB_ROUND_ROBIN_EN is set, the only build that instantiates it.
`ifdef SPRITE_ARB_ROUND_ROBIN_EN
module rr_pick
    import sprite_rom_arbiter_pkg::*;
#(
    parameter int NUM_REQ = SRA_NUM_REQ,
    parameter int PTR_W   = sra_ptr_w(SRA_NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [PTR_W-1:0]   i_ptr,
    output logic [NUM_REQ-1:0] o_gnt
);

    int   w_idx;
    logic w_found;

    always_comb begin
        o_gnt   = '0;
        w_found = 1'b0;
        w_idx   = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_idx = (int'(i_ptr) + k) % NUM_REQ;
            if (!w_found && i_req[w_idx]) begin
                o_gnt[w_idx] = 1'b1;
                w_found      = 1'b1;
            end
        end
    end

endmodule
`endif

// File: rtl/sprite_rom_arbiter.sv
// Sprite ROM arbiter: one grant per cycle onto a shared ROM, fixed-latency tagged responses.
// Define SPRITE_ARB_ROUND_ROBIN_EN for round-robin arbitration; default is fixed priority.
module sprite_rom_arbiter
    import sprite_rom_arbiter_pkg::*;
#(
    parameter int NUM_REQ     = SRA_NUM_REQ,
    parameter int ADDR_W      = SRA_ADDR_W,
    parameter int DATA_W      = SRA_DATA_W,
    parameter int ROM_LATENCY = SRA_ROM_LATENCY
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_REQ-1:0]             req,
    input  logic [NUM_REQ-1:0][ADDR_W-1:0] req_addr,
    output logic [NUM_REQ-1:0]             gnt,
    output logic                           rom_rd,
    output logic [ADDR_W-1:0]              rom_addr,
    input  logic [DATA_W-1:0]              rom_data,
    output logic [NUM_REQ-1:0]             rsp_valid,
    output logic [DATA_W-1:0]              rsp_data,
    output logic                           conflict,
    output logic [SRA_CNT_W-1:0]           conflict_cnt
);

    localparam int PTR_W = sra_ptr_w(NUM_REQ);

    logic [NUM_REQ-1:0]                w_gnt;
    logic [ADDR_W-1:0]                 w_sel_addr;
    logic                              w_conflict;
    logic                              r_rom_rd;
    logic [ADDR_W-1:0]                 r_rom_addr;
    logic [ROM_LATENCY:0][NUM_REQ-1:0] r_tag;
    logic [DATA_W-1:0]                 r_rsp_data;
    logic [SRA_CNT_W-1:0]              r_conflict_cnt;

`ifdef SPRITE_ARB_ROUND_ROBIN_EN
    logic [PTR_W-1:0] r_ptr;
    logic [PTR_W-1:0] w_gnt_idx;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_rr_pick (
        .i_req (req),
        .i_ptr (r_ptr),
        .o_gnt (w_gnt)
    );

    always_comb begin
        w_gnt_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_gnt[i]) w_gnt_idx = PTR_W'(i);
        end
    end

    // Pointer moves past the winner only when something was granted.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ptr <= '0;
        end else if (|w_gnt) begin
            r_ptr <= (w_gnt_idx == PTR_W'(NUM_REQ - 1)) ? '0 : w_gnt_idx + PTR_W'(1);
        end
    end
`else
    // Isolate the lowest set bit: lowest requesting index wins.
    assign w_gnt = req & (~req + NUM_REQ'(1));
`endif

    always_comb begin
        w_sel_addr = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_gnt[i]) w_sel_addr = req_addr[i];
        end
    end

    assign w_conflict = ($countones(req) > 1);

    // Grants made while reset is high never enter the ROM or tag pipeline.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rom_rd       <= 1'b0;
            r_rom_addr     <= '0;
            r_tag          <= '0;
            r_rsp_data     <= DATA_W'(TRANSPARENT);
            r_conflict_cnt <= '0;
        end else begin
            r_rom_rd   <= |w_gnt;
            if (|w_gnt) r_rom_addr <= w_sel_addr;
            r_tag[0]   <= w_gnt;
            for (int k = 1; k <= ROM_LATENCY; k++) begin
                r_tag[k] <= r_tag[k-1];
            end
            r_rsp_data <= rom_data;
            if (w_conflict && (r_conflict_cnt != {SRA_CNT_W{1'b1}})) begin
                r_conflict_cnt <= r_conflict_cnt + SRA_CNT_W'(1);
            end
        end
    end

    assign gnt          = w_gnt;
    assign conflict     = w_conflict;
    assign rom_rd       = r_rom_rd;
    assign rom_addr     = r_rom_addr;
    assign rsp_valid    = r_tag[ROM_LATENCY];
    assign rsp_data     = r_rsp_data;
    assign conflict_cnt = r_conflict_cnt;

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Self-checking bench for sprite_rom_arbiter (fixed priority by default,
// round-robin expectations when SPRITE_ARB_ROUND_ROBIN_EN is defined).
module tb_sprite_rom_arbiter;

    localparam int NUM_REQ     = 4;
    localparam int ADDR_W      = 19;
    localparam int DATA_W      = 12;
    localparam int ROM_LATENCY = 2;
    localparam int W           = NUM_REQ + DATA_W;

    logic                           clk;
    logic                           reset;
    logic [NUM_REQ-1:0]             req;
    logic [NUM_REQ-1:0][ADDR_W-1:0] req_addr;
    logic [NUM_REQ-1:0]             gnt;
    logic                           rom_rd;
    logic [ADDR_W-1:0]              rom_addr;
    logic [DATA_W-1:0]              rom_data;
    logic [NUM_REQ-1:0]             rsp_valid;
    logic [DATA_W-1:0]              rsp_data;
    logic                           conflict;
    logic [15:0]                    conflict_cnt;

    int checks;
    int failures;
    logic mon_en;

    logic [W-1:0] exp_q[$];

    sprite_rom_arbiter #(
        .NUM_REQ     (NUM_REQ),
        .ADDR_W      (ADDR_W),
        .DATA_W      (DATA_W),
        .ROM_LATENCY (ROM_LATENCY)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .req          (req),
        .req_addr     (req_addr),
        .gnt          (gnt),
        .rom_rd       (rom_rd),
        .rom_addr     (rom_addr),
        .rom_data     (rom_data),
        .rsp_valid    (rsp_valid),
        .rsp_data     (rsp_data),
        .conflict     (conflict),
        .conflict_cnt (conflict_cnt)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- ROM model ----------------
    // rom_data is valid ROM_LATENCY-1 cycles after rom_addr, so the registered
    // rsp_data lands ROM_LATENCY+1 cycles after the grant.
    function automatic logic [DATA_W-1:0] rom_f(input logic [ADDR_W-1:0] a);
        logic [ADDR_W-1:0] t;
        t = a * 19'd37 + 19'd5;
        return t[DATA_W-1:0];
    endfunction

    logic [DATA_W-1:0] rom_q;
    always @(posedge clk) rom_q <= rom_f(rom_addr);
    assign rom_data = rom_q;

    // ---------------- reference arbiter ----------------
    function automatic logic [NUM_REQ-1:0] model_gnt(input logic [NUM_REQ-1:0] r, input int ptr);
        logic [NUM_REQ-1:0] g;
        int idx;
        g = '0;
`ifdef SPRITE_ARB_ROUND_ROBIN_EN
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = (ptr + k) % NUM_REQ;
            if (r[idx]) g = NUM_REQ'(1) << idx;
        end
`else
        idx = ptr;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (r[k]) g = NUM_REQ'(1) << k;
        end
`endif
        return g;
    endfunction

    // ---------------- scoreboard / monitor ----------------
    int                 m_ptr;
    logic               m_rom_rd;
    logic [ADDR_W-1:0]  m_rom_addr;
    logic [15:0]        m_cnt;
    logic [NUM_REQ-1:0] e_gnt;
    logic               e_conf;
    logic [ADDR_W-1:0]  e_addr;
    logic [W-1:0]       e_rsp;

    initial begin
        m_ptr      = 0;
        m_rom_rd   = 1'b0;
        m_rom_addr = '0;
        m_cnt      = '0;
    end

    always @(negedge clk) begin
        if (mon_en) begin
            e_gnt  = model_gnt(req, m_ptr);
            e_conf = ($countones(req) > 1);
            checks++;
            if (gnt !== e_gnt) begin
                failures++;
                $display("FAIL sb_gnt: got %b expected %b t=%0t", gnt, e_gnt, $time);
            end
            checks++;
            if (conflict !== e_conf) begin
                failures++;
                $display("FAIL sb_conflict: got %b expected %b t=%0t", conflict, e_conf, $time);
            end
            checks++;
            if (rom_rd !== m_rom_rd || rom_addr !== m_rom_addr) begin
                failures++;
                $display("FAIL sb_rom: got rd=%b addr=%h expected rd=%b addr=%h t=%0t",
                         rom_rd, rom_addr, m_rom_rd, m_rom_addr, $time);
            end
            checks++;
            if (conflict_cnt !== m_cnt) begin
                failures++;
                $display("FAIL sb_cnt: got %h expected %h t=%0t", conflict_cnt, m_cnt, $time);
            end
            if (exp_q.size() == ROM_LATENCY + 1) begin
                e_rsp = exp_q.pop_front();
                checks++;
                if (rsp_valid !== e_rsp[DATA_W +: NUM_REQ] ||
                    ((|e_rsp[DATA_W +: NUM_REQ]) && rsp_data !== e_rsp[DATA_W-1:0])) begin
                    failures++;
                    $display("FAIL sb_rsp: got valid=%b data=%h expected valid=%b data=%h t=%0t",
                             rsp_valid, rsp_data, e_rsp[DATA_W +: NUM_REQ], e_rsp[DATA_W-1:0], $time);
                end
            end
            if (reset) begin
                m_rom_rd   = 1'b0;
                m_rom_addr = '0;
                m_cnt      = '0;
                m_ptr      = 0;
                foreach (exp_q[i]) exp_q[i] = '0;
                exp_q.push_back('0);
            end else begin
                e_addr = '0;
                for (int i = 0; i < NUM_REQ; i++) begin
                    if (e_gnt[i]) begin
                        e_addr = req_addr[i];
                        m_ptr  = (i + 1) % NUM_REQ;
                    end
                end
                m_rom_rd = |e_gnt;
                if (|e_gnt) m_rom_addr = e_addr;
                if (e_conf && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
                exp_q.push_back({e_gnt, rom_f(e_addr)});
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req   = '0;
        step();
        reset = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset = 1'b1;
        req   = '0;
        repeat (2) step();
        mon_en = 1'b1;
        req    = 4'b0110;
        @(negedge clk);
        checks++;
        if (gnt !== 4'b0010 || conflict !== 1'b1) begin
            failures++;
            $display("FAIL reset_comb: got gnt=%b conflict=%b expected gnt=0010 conflict=1", gnt, conflict);
        end
        checks++;
        if (rom_rd !== 1'b0 || rom_addr !== '0 || rsp_valid !== '0 || rsp_data !== '0 || conflict_cnt !== '0) begin
            failures++;
            $display("FAIL reset_state: got rd=%b addr=%h valid=%b data=%h cnt=%h expected all zero",
                     rom_rd, rom_addr, rsp_valid, rsp_data, conflict_cnt);
        end
        step();
        reset = 1'b0;
        req   = '0;
        @(negedge clk);
        checks++;
        if (rom_rd !== 1'b0 || conflict_cnt !== 16'd0) begin
            failures++;
            $display("FAIL reset_discard: got rd=%b cnt=%h expected rd=0 cnt=0", rom_rd, conflict_cnt);
        end
        step();
    endtask

    task automatic test_single();
        req = 4'b0001;
        for (int k = 0; k < 3; k++) begin
            req_addr[0] = ADDR_W'(100 + k);
            @(negedge clk);
            checks++;
            if (gnt !== 4'b0001) begin
                failures++;
                $display("FAIL single_gnt: got %b expected 0001", gnt);
            end
            step();
        end
        req = '0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if (rsp_valid !== 4'b0001 || rsp_data !== rom_f(ADDR_W'(100 + k))) begin
                failures++;
                $display("FAIL single_rsp: got valid=%b data=%h expected valid=0001 data=%h",
                         rsp_valid, rsp_data, rom_f(ADDR_W'(100 + k)));
            end
            step();
        end
    endtask

`ifdef SPRITE_ARB_ROUND_ROBIN_EN
    task automatic test_round_robin();
        logic [NUM_REQ-1:0] exp_g;
        do_reset();
        req = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            exp_g = NUM_REQ'(1) << (k % NUM_REQ);
            @(negedge clk);
            checks++;
            if (gnt !== exp_g) begin
                failures++;
                $display("FAIL rr_gnt: got %b expected %b", gnt, exp_g);
            end
            step();
        end
        req = '0;
        @(negedge clk);
        checks++;
        if (conflict_cnt !== 16'd8) begin
            failures++;
            $display("FAIL rr_cnt: got %0d expected 8", conflict_cnt);
        end
        step();
    endtask
`else
    task automatic test_fixed_priority();
        do_reset();
        req = 4'b1010;
        for (int k = 0; k < 11; k++) begin
            if (k == 8) req = '0;
            @(negedge clk);
            if (k < 8) begin
                checks++;
                if (gnt !== 4'b0010) begin
                    failures++;
                    $display("FAIL fp_gnt: got %b expected 0010", gnt);
                end
            end
            checks++;
            if (rsp_valid[3] !== 1'b0) begin
                failures++;
                $display("FAIL fp_starved: got rsp_valid=%b expected bit3=0", rsp_valid);
            end
            if (k == 8) begin
                checks++;
                if (conflict_cnt !== 16'd8) begin
                    failures++;
                    $display("FAIL fp_cnt: got %0d expected 8", conflict_cnt);
                end
            end
            step();
        end
    endtask
`endif

    task automatic test_reset_midflight();
        req = '0;
        repeat (4) step();
        req         = 4'b0001;
        req_addr[0] = ADDR_W'(55);
        @(negedge clk);
        checks++;
        if (gnt !== 4'b0001) begin
            failures++;
            $display("FAIL mid_gnt: got %b expected 0001", gnt);
        end
        step();
        reset = 1'b1;
        req   = 4'b0010;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            checks++;
            if (rsp_valid !== '0) begin
                failures++;
                $display("FAIL mid_flush: cycle %0d got rsp_valid=%b expected 0000", k, rsp_valid);
            end
            step();
            reset = 1'b0;
            req   = '0;
        end
        req = 4'b1111;
        @(negedge clk);
        checks++;
        if (gnt !== 4'b0001) begin
            failures++;
            $display("FAIL mid_ptr: got gnt=%b expected 0001", gnt);
        end
        step();
        req = '0;
    endtask

    task automatic test_idle_gaps();
        logic [NUM_REQ-1:0] exp_g;
        req         = 4'b0100;
        req_addr[2] = 19'h31234;
        step();
        req = '0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checks++;
            if (rom_rd !== (k == 0) || rom_addr !== 19'h31234 || gnt !== '0) begin
                failures++;
                $display("FAIL idle: cycle %0d got rd=%b addr=%h gnt=%b expected rd=%b addr=31234 gnt=0000",
                         k, rom_rd, rom_addr, gnt, (k == 0));
            end
            step();
        end
`ifdef SPRITE_ARB_ROUND_ROBIN_EN
        exp_g = 4'b1000;
`else
        exp_g = 4'b0001;
`endif
        req = 4'b1111;
        @(negedge clk);
        checks++;
        if (gnt !== exp_g) begin
            failures++;
            $display("FAIL idle_ptr: got gnt=%b expected %b", gnt, exp_g);
        end
        step();
        req = '0;
    endtask

    task automatic test_back_to_back();
        for (int n = 0; n < 300; n++) begin
            req = NUM_REQ'($urandom_range(0, 15));
            for (int i = 0; i < NUM_REQ; i++) req_addr[i] = ADDR_W'($urandom_range(0, (1 << ADDR_W) - 1));
            @(negedge clk);
            checks++;
            if (!$onehot0(gnt) || (gnt & ~req) !== '0 || ((req != '0) !== (gnt != '0))) begin
                failures++;
                $display("FAIL b2b_shape: got gnt=%b for req=%b expected one-hot subset, nonzero iff req", gnt, req);
            end
            step();
        end
        req = '0;
    endtask

    task automatic test_saturation();
        logic [NUM_REQ-1:0] r;
        do_reset();
        for (int n = 0; n < 65534; n++) begin
            r = NUM_REQ'($urandom_range(0, 15));
            if ($countones(r) < 2) r = 4'b1111;
            req = r;
            step();
        end
        req = '0;
        @(negedge clk);
        checks++;
        if (conflict_cnt !== 16'hFFFE) begin
            failures++;
            $display("FAIL sat_pre: got %h expected fffe", conflict_cnt);
        end
        step();
        for (int k = 0; k < 2; k++) begin
            req = 4'b1100;
            repeat (k == 0 ? 3 : 2) step();
            req = '0;
            @(negedge clk);
            checks++;
            if (conflict_cnt !== 16'hFFFF) begin
                failures++;
                $display("FAIL sat_hold: pass %0d got %h expected ffff", k, conflict_cnt);
            end
            step();
        end
    endtask

    // ---------------- sequence / report ----------------
    initial begin
        checks   = 0;
        failures = 0;
        mon_en   = 1'b0;
        reset    = 1'b1;
        req      = '0;
        req_addr = '0;
        test_reset();
        test_single();
`ifdef SPRITE_ARB_ROUND_ROBIN_EN
        test_round_robin();
`else
        test_fixed_priority();
`endif
        test_reset_midflight();
        test_idle_gaps();
        test_back_to_back();
        test_saturation();
        req = '0;
        repeat (ROM_LATENCY + 3) step();
        mon_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
